// File: rtl/axi_rd_arb2_if.sv
// AXI4 read-channel (AR + R) bundle shared by requester and memory ports of axi_rd_arb2.
// master drives the address and accepts data; slave is the responding side.
interface axi_rd_arb2_if #(
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arb2.sv
// Two-requester AXI4 read arbiter: one burst in flight, round-robin with an urgent
// override for requester 1 (display fetch). R data is a combinational passthrough.
module axi_rd_arb2 #(
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic           clk,
  input  logic           rstn,
  axi_rd_arb2_if.slave   s0,
  axi_rd_arb2_if.slave   s1,
  input  logic           s1_urgent,
  axi_rd_arb2_if.master  m,
  output logic           o_err,
  output logic           o_owner
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  err_q, err_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;

  logic grant0, grant1;

  // Urgent wins outright; otherwise a tie goes to whoever was not granted last.
  assign grant1 = (state_q == StIdle) && s1.arvalid &&
                  (s1_urgent || !s0.arvalid || !last_q);
  assign grant0 = (state_q == StIdle) && s0.arvalid && !grant1;

  assign s0.arready = grant0;
  assign s1.arready = grant1;

  assign m.arvalid = (state_q == StAddr);
  assign m.arid    = arid_q;
  assign m.araddr  = araddr_q;
  assign m.arlen   = arlen_q;
  assign m.arsize  = arsize_q;
  assign m.arburst = arburst_q;

  assign s0.rid   = owner_q ? '0 : m.rid;
  assign s0.rdata = owner_q ? '0 : m.rdata;
  assign s0.rresp = owner_q ? '0 : m.rresp;
  assign s0.rlast = owner_q ? 1'b0 : m.rlast;
  assign s1.rid   = owner_q ? m.rid : '0;
  assign s1.rdata = owner_q ? m.rdata : '0;
  assign s1.rresp = owner_q ? m.rresp : '0;
  assign s1.rlast = owner_q ? m.rlast : 1'b0;

  assign o_err   = err_q;
  assign o_owner = owner_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    err_d     = err_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    s0.rvalid = 1'b0;
    s1.rvalid = 1'b0;
    m.rready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          state_d   = StAddr;
          owner_d   = grant1;
          arid_d    = grant1 ? s1.arid    : s0.arid;
          araddr_d  = grant1 ? s1.araddr  : s0.araddr;
          arlen_d   = grant1 ? s1.arlen   : s0.arlen;
          arsize_d  = grant1 ? s1.arsize  : s0.arsize;
          arburst_d = grant1 ? s1.arburst : s0.arburst;
        end
      end
      StAddr: begin
        if (m.arready) state_d = StData;
      end
      StData: begin
        if (owner_q) begin
          s1.rvalid = m.rvalid;
          m.rready  = s1.rready;
        end else begin
          s0.rvalid = m.rvalid;
          m.rready  = s0.rready;
        end
        if (m.rvalid && m.rready && m.rlast) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Beats with no burst outstanding are drained and flagged, never forwarded.
    if (state_q != StData && m.rvalid) begin
      m.rready = 1'b1;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      err_q     <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Directed bench for axi_rd_arb2: single burst, round-robin, urgent override,
// back-pressure, stray beat and mid-burst reset.
module tb_axi_rd_arb2;
  logic clk;
  logic rstn;
  logic s1_urgent;
  logic o_err;
  logic o_owner;
  int   n_total;
  int   n_pass;

  axi_rd_arb2_if s0_if ();
  axi_rd_arb2_if s1_if ();
  axi_rd_arb2_if m_if ();

  axi_rd_arb2 dut (
    .clk       (clk),
    .rstn      (rstn),
    .s0        (s0_if),
    .s1        (s1_if),
    .s1_urgent (s1_urgent),
    .m         (m_if),
    .o_err     (o_err),
    .o_owner   (o_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.arvalid = 0; s0_if.arid = '0; s0_if.araddr = '0; s0_if.arlen = '0;
    s0_if.arsize = 3'd3; s0_if.arburst = 2'd1; s0_if.rready = 0;
    s1_if.arvalid = 0; s1_if.arid = '0; s1_if.araddr = '0; s1_if.arlen = '0;
    s1_if.arsize = 3'd3; s1_if.arburst = 2'd1; s1_if.rready = 0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rid = '0; m_if.rdata = '0;
    m_if.rresp = '0; m_if.rlast = 0;
    s1_urgent = 0;
  endtask

  task automatic apply_reset();
    rstn = 0;
    step();
    rstn = 1;
  endtask

  // One single-beat burst; s0 asks for 0x100/id 1, s1 for 0x200/id 2.
  task automatic arb_round(input logic v0, input logic v1, input logic urg,
                           input logic exp_own, input logic mid_urg);
    s0_if.arvalid = v0; s0_if.araddr = 32'h100; s0_if.arid = 6'd1; s0_if.arlen = 8'd0;
    s1_if.arvalid = v1; s1_if.araddr = 32'h200; s1_if.arid = 6'd2; s1_if.arlen = 8'd0;
    s1_urgent = urg;
    #1;
    check_eq("rr_grant_s0", 64'(s0_if.arready), 64'(!exp_own));
    check_eq("rr_grant_s1", 64'(s1_if.arready), 64'(exp_own));
    check_eq("rr_idle_arvalid", 64'(m_if.arvalid), 64'd0);
    step();
    s0_if.arvalid = 0; s1_if.arvalid = 0; s1_urgent = 0; m_if.arready = 1;
    #1;
    check_eq("rr_m_arvalid", 64'(m_if.arvalid), 64'd1);
    check_eq("rr_m_araddr", 64'(m_if.araddr), exp_own ? 64'h200 : 64'h100);
    check_eq("rr_owner", 64'(o_owner), 64'(exp_own));
    step();
    m_if.arready = 0; m_if.rvalid = 1; m_if.rlast = 1;
    m_if.rid = exp_own ? 6'd2 : 6'd1; m_if.rdata = 64'hA0;
    s0_if.rready = 1; s1_if.rready = 1;
    if (mid_urg) begin
      s1_urgent = 1; s1_if.arvalid = 1;
    end
    #1;
    check_eq("rr_s0_rvalid", 64'(s0_if.rvalid), 64'(!exp_own));
    check_eq("rr_s1_rvalid", 64'(s1_if.rvalid), 64'(exp_own));
    check_eq("rr_data_no_arready", 64'({s0_if.arready, s1_if.arready}), 64'd0);
    if (mid_urg) check_eq("urg_no_preempt_owner", 64'(o_owner), 64'd0);
    step();
    m_if.rvalid = 0; m_if.rlast = 0; s1_urgent = 0; s1_if.arvalid = 0;
    s0_if.rready = 0; s1_if.rready = 0;
  endtask

  initial begin
    int k, recv, cyc;
    logic rr, hs;
    n_total = 0;
    n_pass  = 0;
    rstn = 0;
    clear_inputs();
    #3;
    check_eq("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check_eq("rst_m_araddr", 64'(m_if.araddr), 64'd0);
    check_eq("rst_arready", 64'({s0_if.arready, s1_if.arready}), 64'd0);
    check_eq("rst_rvalid", 64'({s0_if.rvalid, s1_if.rvalid}), 64'd0);
    check_eq("rst_m_rready", 64'(m_if.rready), 64'd0);
    check_eq("rst_err_owner", 64'({o_err, o_owner}), 64'd0);
    step();
    step();
    rstn = 1;

    // Single s0 burst: addr 0x1000, len 3, id 5.
    s0_if.arvalid = 1; s0_if.araddr = 32'h0000_1000; s0_if.arlen = 8'd3; s0_if.arid = 6'd5;
    #1;
    check_eq("single_s0_arready", 64'(s0_if.arready), 64'd1);
    check_eq("single_s1_arready", 64'(s1_if.arready), 64'd0);
    step();
    s0_if.arvalid = 0; m_if.arready = 1;
    #1;
    check_eq("single_m_arvalid", 64'(m_if.arvalid), 64'd1);
    check_eq("single_m_araddr", 64'(m_if.araddr), 64'h1000);
    check_eq("single_m_arlen", 64'(m_if.arlen), 64'd3);
    check_eq("single_m_arid", 64'(m_if.arid), 64'd5);
    check_eq("single_ar_no_arready", 64'(s0_if.arready), 64'd0);
    step();
    m_if.arready = 0; s0_if.rready = 1;
    for (int i = 0; i < 4; i++) begin
      m_if.rvalid = 1; m_if.rid = 6'd5; m_if.rdata = 64'd100 + 64'(i); m_if.rlast = (i == 3);
      #1;
      check_eq("single_s0_rvalid", 64'(s0_if.rvalid), 64'd1);
      check_eq("single_s0_rdata", s0_if.rdata, 64'd100 + 64'(i));
      check_eq("single_s0_rid", 64'(s0_if.rid), 64'd5);
      check_eq("single_s0_rlast", 64'(s0_if.rlast), 64'(i == 3));
      check_eq("single_s1_rvalid", 64'(s1_if.rvalid), 64'd0);
      check_eq("single_m_rready", 64'(m_if.rready), 64'd1);
      step();
    end
    m_if.rvalid = 0; m_if.rlast = 0; s0_if.rready = 0;

    // Fresh pointer so the first tie goes to s0.
    apply_reset();
    arb_round(1, 1, 0, 0, 0);
    arb_round(1, 1, 0, 1, 0);
    arb_round(1, 1, 0, 0, 0);
    arb_round(1, 1, 0, 1, 0);

    // last = 1 here: urgent s1 still wins, then s0; urgent mid-s0 burst is ignored.
    arb_round(1, 1, 1, 1, 0);
    arb_round(1, 1, 0, 0, 1);

    // Back-pressure: delayed AR ready and toggling R ready.
    s0_if.arvalid = 1; s0_if.araddr = 32'h2000; s0_if.arlen = 8'd3; s0_if.arid = 6'd7;
    #1;
    check_eq("bp_arready", 64'(s0_if.arready), 64'd1);
    step();
    s0_if.arvalid = 0; s0_if.araddr = 32'h9999;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_ar_hold_valid", 64'(m_if.arvalid), 64'd1);
      check_eq("bp_ar_hold_addr", 64'(m_if.araddr), 64'h2000);
      step();
    end
    m_if.arready = 1;
    #1;
    check_eq("bp_ar_hs_valid", 64'(m_if.arvalid), 64'd1);
    step();
    m_if.arready = 0;
    k = 0; recv = 0; cyc = 0;
    while (k < 4 && cyc < 20) begin
      rr = (cyc % 2) == 1;
      m_if.rvalid = 1; m_if.rid = 6'd7; m_if.rdata = 64'h200 + 64'(k); m_if.rlast = (k == 3);
      s0_if.rready = rr;
      #1;
      check_eq("bp_m_rready", 64'(m_if.rready), 64'(rr));
      check_eq("bp_s0_rvalid", 64'(s0_if.rvalid), 64'd1);
      hs = m_if.rvalid && m_if.rready;
      if (s0_if.rvalid && s0_if.rready) begin
        check_eq("bp_s0_rdata", s0_if.rdata, 64'h200 + 64'(recv));
        recv++;
      end
      step();
      if (hs) k++;
      cyc++;
    end
    m_if.rvalid = 0; m_if.rlast = 0; s0_if.rready = 0;
    check_eq("bp_beat_count", 64'(recv), 64'd4);
    check_eq("bp_cycles", 64'(cyc), 64'd8);

    // Stray beat in IDLE.
    m_if.rvalid = 1; m_if.rlast = 1;
    #1;
    check_eq("stray_m_rready", 64'(m_if.rready), 64'd1);
    check_eq("stray_rvalid", 64'({s0_if.rvalid, s1_if.rvalid}), 64'd0);
    step();
    m_if.rvalid = 0; m_if.rlast = 0;
    #1;
    check_eq("stray_err_set", 64'(o_err), 64'd1);
    step();
    step();
    check_eq("stray_err_sticky", 64'(o_err), 64'd1);

    // s1 burst of 8, reset after beat 2.
    s1_if.arvalid = 1; s1_if.araddr = 32'h3000; s1_if.arlen = 8'd7; s1_if.arid = 6'd9;
    #1;
    check_eq("rst_mid_arready", 64'(s1_if.arready), 64'd1);
    step();
    s1_if.arvalid = 0; m_if.arready = 1;
    step();
    m_if.arready = 0; s1_if.rready = 1;
    for (int i = 0; i < 2; i++) begin
      m_if.rvalid = 1; m_if.rid = 6'd9; m_if.rdata = 64'(i); m_if.rlast = 0;
      #1;
      check_eq("rst_mid_s1_rvalid", 64'(s1_if.rvalid), 64'd1);
      step();
    end
    m_if.rvalid = 0;
    #1;
    check_eq("rst_mid_owner_pre", 64'(o_owner), 64'd1);
    rstn = 0;
    #1;
    check_eq("rst_mid_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check_eq("rst_mid_m_araddr", 64'(m_if.araddr), 64'd0);
    check_eq("rst_mid_owner", 64'(o_owner), 64'd0);
    check_eq("rst_mid_err", 64'(o_err), 64'd0);
    check_eq("rst_mid_m_rready", 64'(m_if.rready), 64'd0);
    check_eq("rst_mid_rvalid", 64'({s0_if.rvalid, s1_if.rvalid}), 64'd0);
    step();
    rstn = 1;
    m_if.rvalid = 1; m_if.rlast = 0;
    #1;
    check_eq("late_beat_drain", 64'(m_if.rready), 64'd1);
    check_eq("late_beat_s1_rvalid", 64'(s1_if.rvalid), 64'd0);
    step();
    m_if.rvalid = 0;
    #1;
    check_eq("late_beat_err", 64'(o_err), 64'd1);
    step();
    arb_round(0, 1, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
